// File: rtl/dual_port_ram_pkg.sv
// dual_port_ram_pkg: shared word/address widths, depth and data/address types
package dual_port_ram_pkg;
    localparam int DATA_W = 9;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 2**ADDR_W;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/dual_port_ram_if.sv
// dual_port_ram_if: bus bundle for both RAM ports
// ce: chip enable shared by both ports
// we_x/adr_x/din_x: per-port write enable, address, write data
// dout_x: per-port registered read data
interface dual_port_ram_if;
    import dual_port_ram_pkg::*;
    logic  ce;
    logic  we_a;
    logic  we_b;
    addr_t adr_a;
    addr_t adr_b;
    data_t din_a;
    data_t din_b;
    data_t dout_a;
    data_t dout_b;
    modport master (output ce, we_a, we_b, adr_a, adr_b, din_a, din_b, input dout_a, dout_b);
    modport slave  (input ce, we_a, we_b, adr_a, adr_b, din_a, din_b, output dout_a, dout_b);
endinterface

// File: rtl/dual_port_ram.sv
// dual_port_ram: true dual-port synchronous RAM, write-first per port, port A wins write clashes
// clk: rising-edge clock
// nrst: synchronous reset, active-high; clears read data only, never the array
// bus: dual_port_ram_if slave carrying ce and both ports' signals
module dual_port_ram #(
    parameter int DEPTH = dual_port_ram_pkg::DEPTH
) (
    input logic            clk,
    input logic            nrst,
    dual_port_ram_if.slave bus
);
    import dual_port_ram_pkg::*;

    data_t r_mem [DEPTH];
    data_t r_dout_a;
    data_t r_dout_b;
    logic  w_ok_a;
    logic  w_ok_b;
    logic  w_clash;
    data_t w_rd_a;
    data_t w_rd_b;

    // addresses beyond a reduced DEPTH are dropped on write and read as zero
    assign w_ok_a  = int'(bus.adr_a) < DEPTH;
    assign w_ok_b  = int'(bus.adr_b) < DEPTH;
    assign w_clash = bus.we_a && w_ok_a && bus.adr_a == bus.adr_b;
    assign w_rd_a  = w_ok_a ? r_mem[bus.adr_a] : '0;
    assign w_rd_b  = w_ok_b ? r_mem[bus.adr_b] : '0;

    always_ff @(posedge clk) begin
        if (!nrst && bus.ce) begin
            if (bus.we_b && w_ok_b && !w_clash) r_mem[bus.adr_b] <= bus.din_b;
            if (bus.we_a && w_ok_a) r_mem[bus.adr_a] <= bus.din_a;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_dout_a <= '0;
            r_dout_b <= '0;
        end else if (bus.ce) begin
            r_dout_a <= bus.we_a ? bus.din_a : w_rd_a;
            r_dout_b <= bus.we_b ? bus.din_b : w_rd_b;
        end
    end

    assign bus.dout_a = r_dout_a;
    assign bus.dout_b = r_dout_b;
endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: directed and randomized checks of dual_port_ram against an array model
module tb_dual_port_ram;
    import dual_port_ram_pkg::*;

    logic clk = 1'b0;
    logic nrst;
    int   n_tests = 0;
    int   n_fail  = 0;
    data_t m_mem [DEPTH];
    data_t exp_a;
    data_t exp_b;

    dual_port_ram_if bus ();
    dual_port_ram dut (.clk(clk), .nrst(nrst), .bus(bus));

    always #5 clk = ~clk;

    // apply one cycle of stimulus, advance the model at the edge, settle 1 time unit past it
    task automatic tick(input logic rst_i, input logic ce_i, input logic wa, input logic wb,
                        input addr_t aa, input addr_t ab, input data_t da, input data_t db);
        nrst = rst_i; bus.ce = ce_i; bus.we_a = wa; bus.we_b = wb;
        bus.adr_a = aa; bus.adr_b = ab; bus.din_a = da; bus.din_b = db;
        @(posedge clk);
        if (rst_i) begin
            exp_a = '0;
            exp_b = '0;
        end else if (ce_i) begin
            exp_a = wa ? da : m_mem[aa];
            exp_b = wb ? db : m_mem[ab];
            if (wb) m_mem[ab] = db;
            if (wa) m_mem[aa] = da;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1, 1, 0, 0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0, 0, 0);
        n_tests++; if (bus.dout_a !== 9'h000) begin n_fail++; $display("FAIL reset_dout_a: got %h want %h", bus.dout_a, 9'h000); end
        n_tests++; if (bus.dout_b !== 9'h000) begin n_fail++; $display("FAIL reset_dout_b: got %h want %h", bus.dout_b, 9'h000); end
    endtask

    task automatic test_port_a();
        tick(0, 1, 1, 0, 0, 0, 9'h077, 0);
        n_tests++; if (bus.dout_a !== 9'h077) begin n_fail++; $display("FAIL a_wr0_wfirst: got %h want %h", bus.dout_a, 9'h077); end
        tick(0, 1, 1, 0, 1, 0, 9'h0EE, 0);
        n_tests++; if (bus.dout_a !== 9'h0EE) begin n_fail++; $display("FAIL a_wr1_wfirst: got %h want %h", bus.dout_a, 9'h0EE); end
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        n_tests++; if (bus.dout_a !== 9'h077) begin n_fail++; $display("FAIL a_rd0: got %h want %h", bus.dout_a, 9'h077); end
        tick(0, 1, 0, 0, 1, 0, 0, 0);
        n_tests++; if (bus.dout_a !== 9'h0EE) begin n_fail++; $display("FAIL a_rd1: got %h want %h", bus.dout_a, 9'h0EE); end
    endtask

    task automatic test_port_b();
        tick(0, 1, 0, 1, 0, 2, 0, 9'h033);
        n_tests++; if (bus.dout_b !== 9'h033) begin n_fail++; $display("FAIL b_wr2_wfirst: got %h want %h", bus.dout_b, 9'h033); end
        tick(0, 1, 0, 1, 0, 3, 0, 9'h0AA);
        n_tests++; if (bus.dout_b !== 9'h0AA) begin n_fail++; $display("FAIL b_wr3_wfirst: got %h want %h", bus.dout_b, 9'h0AA); end
        tick(0, 1, 0, 0, 0, 2, 0, 0);
        n_tests++; if (bus.dout_b !== 9'h033) begin n_fail++; $display("FAIL b_rd2: got %h want %h", bus.dout_b, 9'h033); end
        tick(0, 1, 0, 0, 2, 3, 0, 0);
        n_tests++; if (bus.dout_b !== 9'h0AA) begin n_fail++; $display("FAIL b_rd3: got %h want %h", bus.dout_b, 9'h0AA); end
        n_tests++; if (bus.dout_a !== 9'h033) begin n_fail++; $display("FAIL a_cross_rd2: got %h want %h", bus.dout_a, 9'h033); end
    endtask

    task automatic test_ce();
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 1, addr_t'(i), addr_t'(i + 1), 9'h1FF, 9'h1FE);
            n_tests++; if (bus.dout_a !== 9'h033) begin n_fail++; $display("FAIL ce_hold_a: got %h want %h", bus.dout_a, 9'h033); end
            n_tests++; if (bus.dout_b !== 9'h0AA) begin n_fail++; $display("FAIL ce_hold_b: got %h want %h", bus.dout_b, 9'h0AA); end
        end
        tick(0, 1, 0, 0, 0, 1, 0, 0);
        n_tests++; if (bus.dout_a !== 9'h077) begin n_fail++; $display("FAIL ce_nowrite_a: got %h want %h", bus.dout_a, 9'h077); end
        n_tests++; if (bus.dout_b !== 9'h0EE) begin n_fail++; $display("FAIL ce_nowrite_b: got %h want %h", bus.dout_b, 9'h0EE); end
    endtask

    task automatic test_reset_preserve();
        tick(1, 1, 1, 1, 0, 1, 9'h100, 9'h101);
        tick(1, 1, 1, 1, 2, 3, 9'h102, 9'h103);
        n_tests++; if (bus.dout_a !== 9'h000) begin n_fail++; $display("FAIL rst2_dout_a: got %h want %h", bus.dout_a, 9'h000); end
        n_tests++; if (bus.dout_b !== 9'h000) begin n_fail++; $display("FAIL rst2_dout_b: got %h want %h", bus.dout_b, 9'h000); end
        tick(0, 1, 0, 0, 0, 1, 0, 0);
        n_tests++; if (bus.dout_a !== 9'h077) begin n_fail++; $display("FAIL rst_keep0: got %h want %h", bus.dout_a, 9'h077); end
        n_tests++; if (bus.dout_b !== 9'h0EE) begin n_fail++; $display("FAIL rst_keep1: got %h want %h", bus.dout_b, 9'h0EE); end
        tick(0, 1, 0, 0, 2, 3, 0, 0);
        n_tests++; if (bus.dout_a !== 9'h033) begin n_fail++; $display("FAIL rst_keep2: got %h want %h", bus.dout_a, 9'h033); end
        n_tests++; if (bus.dout_b !== 9'h0AA) begin n_fail++; $display("FAIL rst_keep3: got %h want %h", bus.dout_b, 9'h0AA); end
    endtask

    task automatic test_collision();
        tick(0, 1, 1, 1, 5, 5, 9'h011, 9'h022);
        n_tests++; if (bus.dout_a !== 9'h011) begin n_fail++; $display("FAIL clash_wfirst_a: got %h want %h", bus.dout_a, 9'h011); end
        n_tests++; if (bus.dout_b !== 9'h022) begin n_fail++; $display("FAIL clash_wfirst_b: got %h want %h", bus.dout_b, 9'h022); end
        tick(0, 1, 0, 0, 5, 5, 0, 0);
        n_tests++; if (bus.dout_a !== 9'h011) begin n_fail++; $display("FAIL clash_rd_a: got %h want %h", bus.dout_a, 9'h011); end
        n_tests++; if (bus.dout_b !== 9'h011) begin n_fail++; $display("FAIL clash_rd_b: got %h want %h", bus.dout_b, 9'h011); end
    endtask

    task automatic test_read_during_write();
        tick(0, 1, 1, 0, 6, 0, 9'h055, 0);
        tick(0, 1, 1, 0, 6, 6, 9'h1FF, 0);
        n_tests++; if (bus.dout_b !== 9'h055) begin n_fail++; $display("FAIL rdw_old: got %h want %h", bus.dout_b, 9'h055); end
        tick(0, 1, 0, 0, 0, 6, 0, 0);
        n_tests++; if (bus.dout_b !== 9'h1FF) begin n_fail++; $display("FAIL rdw_new: got %h want %h", bus.dout_b, 9'h1FF); end
        for (int i = 0; i < 3; i++) begin
            data_t d [4];
            d[0] = data_t'(9'h077 + i); d[1] = data_t'(9'h0EE - i);
            d[2] = data_t'(9'h033 + i); d[3] = data_t'(9'h0AA + i);
            tick(0, 1, 1, 1, addr_t'(2*i), addr_t'(2*i + 2), d[0], d[2]);
            tick(0, 1, 1, 1, addr_t'(2*i + 1), addr_t'(2*i + 3), d[1], d[3]);
            for (int k = 0; k < 4; k++) begin
                tick(0, 1, 0, 0, addr_t'(2*i + k), addr_t'(2*i + 3 - k), 0, 0);
                n_tests++; if (bus.dout_a !== d[k]) begin n_fail++; $display("FAIL loop_rd_a i=%0d k=%0d: got %h want %h", i, k, bus.dout_a, d[k]); end
                n_tests++; if (bus.dout_b !== d[3-k]) begin n_fail++; $display("FAIL loop_rd_b i=%0d k=%0d: got %h want %h", i, k, bus.dout_b, d[3-k]); end
            end
        end
    endtask

    task automatic test_boundary();
        tick(0, 1, 1, 1, 511, 0, 9'h1A5, 9'h05A);
        tick(0, 1, 0, 0, 0, 511, 0, 0);
        n_tests++; if (bus.dout_a !== 9'h05A) begin n_fail++; $display("FAIL bound_adr0: got %h want %h", bus.dout_a, 9'h05A); end
        n_tests++; if (bus.dout_b !== 9'h1A5) begin n_fail++; $display("FAIL bound_adr511: got %h want %h", bus.dout_b, 9'h1A5); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) tick(0, 1, 1, 0, addr_t'(i), 0, data_t'($urandom), 0);
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 31) == 0, $urandom_range(0, 7) != 0,
                 1'($urandom), 1'($urandom),
                 addr_t'($urandom_range(0, 15)), addr_t'($urandom_range(0, 15)),
                 data_t'($urandom), data_t'($urandom));
            n_tests++; if (bus.dout_a !== exp_a) begin n_fail++; $display("FAIL rand_a cyc=%0d: got %h want %h", i, bus.dout_a, exp_a); end
            n_tests++; if (bus.dout_b !== exp_b) begin n_fail++; $display("FAIL rand_b cyc=%0d: got %h want %h", i, bus.dout_b, exp_b); end
        end
    endtask

    initial begin
        test_reset();
        test_port_a();
        test_port_b();
        test_ce();
        test_reset_preserve();
        test_collision();
        test_read_during_write();
        test_boundary();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
